// File: rtl/cam_pkg.sv
// Shared CAM constants and opcode encoding, used by the label decoder and the encoder.
package cam_pkg;
    localparam int NUM_ENTRIES = 32;
    localparam int LABEL_W     = 5;

    typedef enum logic [1:0] {
        OP_WRITE     = 2'b00,
        OP_INVAL     = 2'b01,
        OP_INVAL_ALL = 2'b10,
        OP_NOP       = 2'b11
    } cam_op_t;
endpackage

// File: rtl/cam_label_decoder.sv
// Two-stage label-to-word-line decoder with valid/ready flow control and a
// running occupancy bitmap of the CAM entries.
module cam_label_decoder #(
    parameter int NUM_ENTRIES = cam_pkg::NUM_ENTRIES,
    parameter int LABEL_W     = cam_pkg::LABEL_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_op,
    input  logic [LABEL_W-1:0]     in_label,
    output logic                   wl_valid,
    input  logic                   wl_ready,
    output logic [NUM_ENTRIES-1:0] wl_en,
    output logic [1:0]             wl_op,
    output logic [NUM_ENTRIES-1:0] valid_map,
    output logic [LABEL_W:0]       used_cnt,
    output logic                   full,
    output logic                   overwrite
);
    import cam_pkg::*;

    function automatic logic [NUM_ENTRIES-1:0] decode(input logic [1:0] op,
                                                      input logic [LABEL_W-1:0] lbl);
        logic [NUM_ENTRIES-1:0] d;
        d = '0;
        case (op)
            OP_WRITE, OP_INVAL: d = NUM_ENTRIES'(1) << lbl;
            OP_INVAL_ALL:       d = '1;
            default:            d = '0;
        endcase
        return d;
    endfunction

    logic                   s1_valid;
    logic [1:0]             s1_op;
    logic [LABEL_W-1:0]     s1_label;
    logic                   s2_advance;
    logic                   in_range;
    logic [1:0]             eff_op;
    logic [NUM_ENTRIES-1:0] dec;
    logic                   bit_set;
    logic [NUM_ENTRIES-1:0] map_nxt;
    logic [LABEL_W:0]       cnt_nxt;
    logic                   ovw_nxt;

    assign s2_advance = !wl_valid || wl_ready;
    assign in_ready   = !s1_valid || s2_advance;
    assign full       = (used_cnt == (LABEL_W+1)'(NUM_ENTRIES));

    // Labels beyond the array are demoted to NOP so they never touch valid_map.
    assign in_range = ({1'b0, s1_label} < (LABEL_W+1)'(NUM_ENTRIES));
    assign eff_op   = in_range ? s1_op : OP_NOP;
    assign dec      = decode(eff_op, s1_label);
    assign bit_set  = |(valid_map & dec);

    always_comb begin
        map_nxt = valid_map;
        cnt_nxt = used_cnt;
        ovw_nxt = 1'b0;
        case (eff_op)
            OP_WRITE: begin
                map_nxt = valid_map | dec;
                if (bit_set) ovw_nxt = 1'b1;
                else         cnt_nxt = used_cnt + (LABEL_W+1)'(1);
            end
            OP_INVAL: begin
                map_nxt = valid_map & ~dec;
                if (bit_set) cnt_nxt = used_cnt - (LABEL_W+1)'(1);
            end
            OP_INVAL_ALL: begin
                map_nxt = '0;
                cnt_nxt = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= 2'b00;
            s1_label  <= '0;
            wl_valid  <= 1'b0;
            wl_en     <= '0;
            wl_op     <= 2'b00;
            valid_map <= '0;
            used_cnt  <= '0;
            overwrite <= 1'b0;
        end else begin
            // S1: capture the accepted command
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op    <= in_op;
                    s1_label <= in_label;
                end
            end
            overwrite <= 1'b0;
            // S2: decoded word-line register; occupancy commits on the same edge
            if (s2_advance) begin
                wl_valid <= s1_valid;
                if (s1_valid) begin
                    wl_en     <= dec;
                    wl_op     <= eff_op;
                    valid_map <= map_nxt;
                    used_cnt  <= cnt_nxt;
                    overwrite <= ovw_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_cam_label_decoder.sv
// Directed and randomized checks of cam_label_decoder against a transaction-level
// model: a FIFO of accepted commands and a bit-array image of the CAM occupancy.
module tb_cam_label_decoder;
    import cam_pkg::*;

    typedef struct packed {
        logic [1:0] op;
        logic [4:0] lbl;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'b11;
    logic [4:0]  in_label = '0;
    logic        wl_valid;
    logic        wl_ready = 1'b1;
    logic [31:0] wl_en;
    logic [1:0]  wl_op;
    logic [31:0] valid_map;
    logic [5:0]  used_cnt;
    logic        full;
    logic        overwrite;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_wl  = 0;
    cmd_t        q[$];
    logic [31:0] mdl_map = '0;
    logic        is_new = 1'b1;
    logic [31:0] held_en = '0;
    logic [1:0]  held_op = '0;

    cam_label_decoder dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_label(in_label),
        .wl_valid(wl_valid), .wl_ready(wl_ready), .wl_en(wl_en), .wl_op(wl_op),
        .valid_map(valid_map), .used_cnt(used_cnt), .full(full), .overwrite(overwrite)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_en(input cmd_t c);
        case (c.op)
            OP_WRITE, OP_INVAL: return 32'h1 << c.lbl;
            OP_INVAL_ALL:       return 32'hFFFF_FFFF;
            default:            return 32'h0;
        endcase
    endfunction

    task automatic monitor();
        cmd_t c;
        logic exp_ovw;
        if (wl_valid) begin
            if (is_new) begin
                if (q.size() == 0) begin
                    chk("unexpected_wl", 1, 0);
                end else begin
                    c = q.pop_front();
                    n_wl++;
                    chk("wl_en", wl_en, exp_en(c));
                    chk("wl_op", wl_op, c.op);
                    exp_ovw = (c.op == OP_WRITE) && mdl_map[c.lbl];
                    case (c.op)
                        OP_WRITE:     mdl_map[c.lbl] = 1'b1;
                        OP_INVAL:     mdl_map[c.lbl] = 1'b0;
                        OP_INVAL_ALL: mdl_map = '0;
                        default: ;
                    endcase
                    chk("overwrite", overwrite, exp_ovw);
                end
                held_en = wl_en;
                held_op = wl_op;
            end else begin
                chk("hold_en", wl_en, held_en);
                chk("hold_op", wl_op, held_op);
                chk("overwrite_idle", overwrite, 0);
            end
        end else begin
            chk("overwrite_idle", overwrite, 0);
        end
        chk("valid_map", valid_map, mdl_map);
        chk("used_cnt", used_cnt, $countones(mdl_map));
        chk("full", full, mdl_map == 32'hFFFF_FFFF);
    endtask

    task automatic cyc(input logic v, input logic [1:0] op, input logic [4:0] lbl, input logic rdy);
        cmd_t c;
        @(negedge clk);
        monitor();
        in_valid = v;
        in_op    = op;
        in_label = lbl;
        wl_ready = rdy;
        #1;
        if (v && in_ready) begin
            c.op  = op;
            c.lbl = lbl;
            q.push_back(c);
        end
        is_new = !wl_valid || rdy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, OP_NOP, 5'd0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_wl_valid", wl_valid, 0);
        chk("rst_wl_en", wl_en, 0);
        chk("rst_wl_op", wl_op, 0);
        chk("rst_valid_map", valid_map, 0);
        chk("rst_used_cnt", used_cnt, 0);
        chk("rst_full", full, 0);
        chk("rst_overwrite", overwrite, 0);
        q.delete();
        mdl_map = '0;
        is_new  = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
    endtask

    initial begin
        int wl_before;
        logic [4:0] lbl7 [7];
        lbl7 = '{5'd0, 5'd4, 5'd9, 5'd13, 5'd20, 5'd26, 5'd31};

        do_reset();

        // Single WRITE to label 5 and its pipeline latency
        cyc(1'b1, OP_WRITE, 5'd5, 1'b1);
        cyc(1'b0, OP_NOP, 5'd0, 1'b1);
        chk("lat_s1_only", wl_valid, 0);
        cyc(1'b0, OP_NOP, 5'd0, 1'b1);
        chk("lat_wl_valid", wl_valid, 1);
        chk("lat_wl_en", wl_en, 32'h0000_0020);
        idle(2);
        chk("w5_map", valid_map, 32'h20);
        chk("w5_cnt", used_cnt, 1);

        // Back-to-back fill of every entry
        do_reset();
        wl_before = n_wl;
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, OP_WRITE, 5'(i), 1'b1);
            chk("stream_in_ready", in_ready, 1);
            if (i >= 2) chk("stream_wl_valid", wl_valid, 1);
        end
        idle(3);
        chk("fill_count", n_wl - wl_before, 32);
        chk("fill_full", full, 1);
        chk("fill_cnt", used_cnt, 32);
        cyc(1'b1, OP_WRITE, 5'd17, 1'b1);
        idle(3);

        // Downstream stall for four cycles in the middle of a stream
        do_reset();
        wl_before = n_wl;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, OP_WRITE, 5'($urandom_range(31)), !(i >= 3 && i < 7));
            if (i == 4) chk("stall_in_ready", in_ready, 0);
        end
        idle(4);
        chk("stall_drained", q.size(), 0);

        // Overwrite and double invalidate of label 3
        do_reset();
        cyc(1'b1, OP_WRITE, 5'd3, 1'b1);
        cyc(1'b1, OP_WRITE, 5'd3, 1'b1);
        idle(3);
        chk("ovw_cnt", used_cnt, 1);
        cyc(1'b1, OP_INVAL, 5'd3, 1'b1);
        idle(3);
        chk("inv_cnt", used_cnt, 0);
        cyc(1'b1, OP_INVAL, 5'd3, 1'b1);
        idle(3);
        chk("inv2_cnt", used_cnt, 0);

        // INVALIDATE_ALL with seven entries occupied
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1'b1, OP_WRITE, lbl7[i], 1'b1);
        idle(3);
        chk("seven_cnt", used_cnt, 7);
        cyc(1'b1, OP_INVAL_ALL, 5'($urandom_range(31)), 1'b1);
        idle(3);
        chk("inval_all_map", valid_map, 0);
        chk("inval_all_cnt", used_cnt, 0);

        // Reset asserted with two commands in flight
        do_reset();
        cyc(1'b1, OP_WRITE, 5'd8, 1'b1);
        cyc(1'b1, OP_WRITE, 5'd9, 1'b1);
        do_reset();
        idle(5);
        chk("dropped_map", valid_map, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(1'($urandom_range(1)), 2'($urandom_range(3)), 5'($urandom_range(31)),
                ($urandom_range(9) < 7));
        end
        idle(6);
        chk("random_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
